vram_arbiter: RTL and testbench

Slot-based arbiter sharing one single-port video RAM among three requesters: the background/pattern display fetcher, the sprite fetcher and the CPU port. Access slots are paced by the CRT timing generator's `h_en` strobe, and priorities follow the raster: display first during active pixels, sprites first during blanking. A periodic reserved CPU slot bounds CPU latency. The block sits between the timing generator, the fetch engines, the CPU bus bridge and the VRAM macro.

---
 rtl/vram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Slot-paced arbiter sharing one single-port VRAM among display, sprite and CPU requesters.
// Grants are registered one clock after the slot; read data returns through an owner-tag pipeline.
module vram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 2,
    parameter int CPU_SLOT_N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              h_en,
    input  logic              h_active,
    input  logic              h_end,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_rvalid,
    input  logic              sp_req,
    input  logic [ADDR_W-1:0] sp_addr,
    output logic              sp_ack,
    output logic              sp_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(CPU_SLOT_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPU_SLOT_N - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_SP   = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic              slot;
    logic              reserved;
    logic              disp_elig, sp_elig, cpu_elig;
    owner_e            grant_d;
    owner_e            tag_in_d;
    owner_e            tag_q [MEM_LAT];
    owner_e            tag_out;

    logic              disp_ack_q, sp_ack_q, cpu_ack_q;
    logic              disp_ack_d, sp_ack_d, cpu_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              disp_rvalid_q, sp_rvalid_q, cpu_rvalid_q;
    logic              disp_rvalid_d, sp_rvalid_d, cpu_rvalid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    assign slot     = !cs || h_en;
    // h_end clears the count before the reserved-slot test, so the line-end slot is never reserved.
    assign reserved = cs && !h_end && (slot_cnt_q == CNT_LAST);

    // A pending ack blocks its own requester, so back-to-back slots cannot grant a stale request.
    assign disp_elig = cs && disp_req && !disp_ack_q;
    assign sp_elig   = cs && sp_req && !sp_ack_q;
    assign cpu_elig  = cpu_req && !cpu_ack_q;

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        if (!cs) begin
            slot_cnt_d = '0;
        end else if (slot) begin
            if (h_end || slot_cnt_q == CNT_LAST) begin
                slot_cnt_d = '0;
            end else begin
                slot_cnt_d = slot_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        grant_d = OWN_NONE;
        if (slot) begin
            if (reserved && cpu_elig) begin
                grant_d = OWN_CPU;
            end else if (h_active) begin
                if (disp_elig)      grant_d = OWN_DISP;
                else if (cpu_elig)  grant_d = OWN_CPU;
                else if (sp_elig)   grant_d = OWN_SP;
            end else begin
                if (sp_elig)        grant_d = OWN_SP;
                else if (cpu_elig)  grant_d = OWN_CPU;
                else if (disp_elig) grant_d = OWN_DISP;
            end
        end
    end

    always_comb begin
        disp_ack_d  = (grant_d == OWN_DISP);
        sp_ack_d    = (grant_d == OWN_SP);
        cpu_ack_d   = (grant_d == OWN_CPU);
        mem_en_d    = (grant_d != OWN_NONE);
        mem_we_d    = (grant_d == OWN_CPU) && cpu_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_in_d    = grant_d;
        case (grant_d)
            OWN_DISP: mem_addr_d = disp_addr;
            OWN_SP:   mem_addr_d = sp_addr;
            OWN_CPU: begin
                mem_addr_d  = cpu_addr;
                mem_wdata_d = cpu_wdata;
                if (cpu_we) tag_in_d = OWN_NONE;
            end
            default: ;
        endcase
    end

    assign tag_out = tag_q[MEM_LAT-1];

    always_comb begin
        disp_rvalid_d = (tag_out == OWN_DISP);
        sp_rvalid_d   = (tag_out == OWN_SP);
        cpu_rvalid_d  = (tag_out == OWN_CPU);
        rd_data_d     = rd_data_q;
        if (tag_out != OWN_NONE) rd_data_d = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q    <= '0;
            disp_ack_q    <= 1'b0;
            sp_ack_q      <= 1'b0;
            cpu_ack_q     <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            disp_rvalid_q <= 1'b0;
            sp_rvalid_q   <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            rd_data_q     <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= OWN_NONE;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            disp_ack_q    <= disp_ack_d;
            sp_ack_q      <= sp_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            disp_rvalid_q <= disp_rvalid_d;
            sp_rvalid_q   <= sp_rvalid_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            rd_data_q     <= rd_data_d;
            tag_q[0]      <= tag_in_d;
            for (int i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign disp_ack    = disp_ack_q;
    assign sp_ack      = sp_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_rvalid = disp_rvalid_q;
    assign sp_rvalid   = sp_rvalid_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: table of single-slot arbitration vectors checked through command and
// read-return scoreboards, plus hand sequences for reset, CPU read path, cs=0 bursts and reset mid-read.
module tb_vram_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int MEM_LAT = 2;
    localparam int CPU_SLOT_N = 4;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_DISP = 2'd1;
    localparam logic [1:0] G_SP   = 2'd2;
    localparam logic [1:0] G_CPU  = 2'd3;

    logic clk = 1'b0;
    logic reset, cs, h_en, h_active, h_end;
    logic disp_req, sp_req, cpu_req, cpu_we;
    logic [ADDR_W-1:0] disp_addr, sp_addr, cpu_addr, mem_addr;
    logic [DATA_W-1:0] cpu_wdata, rd_data, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic disp_ack, disp_rvalid, sp_ack, sp_rvalid, cpu_ack, cpu_rvalid, mem_en, mem_we;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .CPU_SLOT_N(CPU_SLOT_N)) dut (
        .clk(clk), .reset(reset), .cs(cs), .h_en(h_en), .h_active(h_active), .h_end(h_end),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rvalid(disp_rvalid),
        .sp_req(sp_req), .sp_addr(sp_addr), .sp_ack(sp_ack), .sp_rvalid(sp_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int n_cpu_ack = 0, n_disp_ack = 0, n_mem_en = 0, n_disp_rv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_f(logic [ADDR_W-1:0] a);
        if (a == 14'h1234) return 8'hA5;
        return a[7:0] ^ 8'h5A;
    endfunction

    // VRAM model: registered read, data visible the cycle after mem_en.
    always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_f(mem_addr);

    function automatic logic [2:0] oh(logic [1:0] w);
        case (w)
            G_DISP:  return 3'b100;
            G_SP:    return 3'b010;
            G_CPU:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]        who;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } cmd_t;
    typedef struct {
        logic [1:0]        who;
        logic [DATA_W-1:0] data;
        int                at;
    } rd_t;
    cmd_t cmd_q[$];
    rd_t  rd_q[$];

    always @(negedge clk) begin
        cmd_t c;
        rd_t  r;
        if (mon_en) begin
            if (cpu_ack)  n_cpu_ack++;
            if (disp_ack) n_disp_ack++;
            if (mem_en)   n_mem_en++;
            if (disp_rvalid) n_disp_rv++;
            if (mem_en || disp_ack || sp_ack || cpu_ack) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {28'd0, mem_en, disp_ack, sp_ack, cpu_ack}, 32'd0);
                end else begin
                    c = cmd_q.pop_front();
                    chk("grant", {29'd0, disp_ack, sp_ack, cpu_ack}, {29'd0, oh(c.who)});
                    chk("mem_en", {31'd0, mem_en}, 32'd1);
                    chk("mem_addr", {18'd0, mem_addr}, {18'd0, c.addr});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, c.we});
                    if (c.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, c.wdata});
                    else rd_q.push_back('{c.who, mem_f(c.addr), cyc + MEM_LAT});
                end
            end
            if (disp_rvalid || sp_rvalid || cpu_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", {29'd0, disp_rvalid, sp_rvalid, cpu_rvalid}, 32'd0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rvalid_owner", {29'd0, disp_rvalid, sp_rvalid, cpu_rvalid}, {29'd0, oh(r.who)});
                    chk("rd_data", {24'd0, rd_data}, {24'd0, r.data});
                    chk("rvalid_cycle", cyc, r.at);
                end
            end
        end
    end

    typedef struct {
        logic       cs, ha, he, d, s, c, we;
        logic [1:0] exp;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t V(logic cs_, ha, he, d, s, c, we, logic [1:0] e);
        vec_t v;
        v.cs = cs_; v.ha = ha; v.he = he; v.d = d; v.s = s; v.c = c; v.we = we; v.exp = e;
        return v;
    endfunction

    task automatic drop_reqs();
        h_en = 1'b0; h_end = 1'b0;
        disp_req = 1'b0; sp_req = 1'b0; cpu_req = 1'b0;
    endtask

    task automatic run_vec(vec_t v, int idx);
        cmd_t c;
        @(posedge clk); #1;
        cs = v.cs; h_en = 1'b1; h_active = v.ha; h_end = v.he;
        disp_req = v.d; sp_req = v.s; cpu_req = v.c; cpu_we = v.we;
        disp_addr = ADDR_W'(32'h100 + idx);
        sp_addr   = ADDR_W'(32'h200 + idx);
        cpu_addr  = ADDR_W'(32'h300 + idx);
        cpu_wdata = DATA_W'(32'h40 + idx);
        if (v.exp != G_NONE) begin
            c.who = v.exp; c.we = (v.exp == G_CPU) && v.we; c.wdata = cpu_wdata;
            c.addr = (v.exp == G_DISP) ? disp_addr : (v.exp == G_SP) ? sp_addr : cpu_addr;
            cmd_q.push_back(c);
        end
        @(posedge clk); #1;
        drop_reqs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        cmd_t c;
        bit got;
        int k;

        // Reset with every request asserted.
        reset = 1'b1; cs = 1'b0; h_en = 1'b1; h_active = 1'b1; h_end = 1'b0;
        disp_req = 1'b1; sp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
        disp_addr = 14'h0011; sp_addr = 14'h0022; cpu_addr = 14'h0033; cpu_wdata = 8'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_ctl", {24'd0, disp_ack, disp_rvalid, sp_ack, sp_rvalid, cpu_ack, cpu_rvalid, mem_en, mem_we}, 32'd0);
            chk("reset_data", {mem_addr, mem_wdata, rd_data}, 32'd0);
        end
        reset = 1'b0;
        drop_reqs();
        @(negedge clk);
        chk("mem_en_after_reset", {31'd0, mem_en}, 32'd0);
        mon_en = 1'b1;

        // Arbitration table; expected grants follow the slot count from reset (0).
        for (int i = 0; i < 2; i++) begin
            vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
            vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
            vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
            vt.push_back(V(1,1,0, 1,0,1,0, G_CPU));
        end
        vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
        vt.push_back(V(1,1,1, 1,0,1,0, G_DISP));   // h_end at count 1
        vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
        vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
        vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
        vt.push_back(V(1,1,0, 1,0,1,0, G_CPU));
        vt.push_back(V(1,0,0, 1,1,1,0, G_SP));     // blanking
        vt.push_back(V(1,0,0, 1,1,1,0, G_SP));
        vt.push_back(V(1,0,0, 1,1,1,0, G_SP));
        vt.push_back(V(1,0,0, 1,1,1,0, G_CPU));
        vt.push_back(V(1,0,0, 1,0,0,0, G_DISP));
        vt.push_back(V(1,0,0, 1,0,1,0, G_CPU));
        vt.push_back(V(1,1,0, 0,1,1,0, G_CPU));
        vt.push_back(V(1,1,0, 1,1,0,0, G_DISP));   // reserved slot, CPU idle
        vt.push_back(V(1,1,0, 0,0,0,0, G_NONE));
        vt.push_back(V(1,0,0, 0,1,0,0, G_SP));
        vt.push_back(V(1,0,0, 0,1,0,0, G_SP));
        vt.push_back(V(1,0,1, 0,1,1,0, G_SP));     // h_end on reserved count: clear wins
        vt.push_back(V(0,1,0, 1,1,1,1, G_CPU));    // cs=0, only CPU eligible
        vt.push_back(V(0,0,0, 1,1,0,0, G_NONE));
        vt.push_back(V(1,1,0, 1,0,1,0, G_DISP));
        vt.push_back(V(1,0,0, 0,0,1,1, G_CPU));
        foreach (vt[i]) run_vec(vt[i], i);
        repeat (MEM_LAT + 3) @(posedge clk);
        #1;

        // CPU read path timing.
        cs = 1'b1; h_en = 1'b1; h_active = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
        c.who = G_CPU; c.addr = 14'h1234; c.we = 1'b0; c.wdata = '0;
        cmd_q.push_back(c);
        @(posedge clk); #1;
        drop_reqs();
        @(negedge clk);
        chk("cpurd_t1", {15'd0, mem_en, cpu_ack, mem_addr}, {15'd0, 1'b1, 1'b1, 14'h1234});
        @(negedge clk);
        chk("cpurd_t2_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        @(negedge clk);
        chk("cpurd_t3", {21'd0, cpu_rvalid, disp_rvalid, sp_rvalid, rd_data}, {21'd0, 3'b100, 8'hA5});
        @(posedge clk); #1;

        // cs=0 CPU write burst with a display request that must be ignored.
        n_cpu_ack = 0; n_disp_ack = 0; n_mem_en = 0;
        cs = 1'b0; h_en = 1'b0; disp_req = 1'b1; disp_addr = 14'h0777;
        for (k = 0; k < 4; k++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ADDR_W'(k); cpu_wdata = DATA_W'(8'hC0 + k);
            c.who = G_CPU; c.addr = cpu_addr; c.we = 1'b1; c.wdata = cpu_wdata;
            cmd_q.push_back(c);
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                @(negedge clk);
                if (cpu_ack) got = 1'b1;
            end
            if (!got) chk("burst_ack_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; disp_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("burst_cpu_acks", n_cpu_ack, 4);
        chk("burst_disp_acks", n_disp_ack, 0);
        chk("burst_mem_en", n_mem_en, 4);

        // Reset while a display read is in flight.
        cs = 1'b1; h_en = 1'b1; h_active = 1'b1; disp_req = 1'b1; disp_addr = 14'h0ABC;
        c.who = G_DISP; c.addr = 14'h0ABC; c.we = 1'b0; c.wdata = '0;
        cmd_q.push_back(c);
        @(posedge clk); #1;
        drop_reqs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rd_q.delete();
        n_disp_rv = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("flushed_disp_rvalid", n_disp_rv, 0);
        h_en = 1'b1; disp_req = 1'b1; disp_addr = 14'h0ABD;
        c.addr = 14'h0ABD;
        cmd_q.push_back(c);
        @(posedge clk); #1;
        drop_reqs();
        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            if (disp_rvalid) got = 1'b1;
        end
        chk("post_reset_read", {31'd0, got}, 32'd1);

        repeat (6) @(posedge clk);
        #1;
        chk("cmd_queue_empty", cmd_q.size(), 0);
        chk("rd_queue_empty", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
